// File: rtl/temp_uart_tx.sv
// Temperature report line transmitter: 16-char ASCII line as 8N1 UART.
// Define TEMP_UART_PARITY_EN to insert an even-parity bit per character.
module temp_uart_tx #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [3:0] temp_value_ones,
   input  logic [3:0] temp_value_tens,
   input  logic [3:0] temp_value_huns,
   input  logic       temp_value_sign,
   input  logic [3:0] temp_delta_ones,
   input  logic [3:0] temp_delta_tens,
   input  logic [3:0] temp_delta_huns,
   input  logic       temp_delta_sign,
   input  logic [1:0] state,
   output logic       tx,
   output logic       busy,
   output logic       done
);

   typedef enum logic [2:0] {
      IDLE,
      START_BIT,
      DATA,
`ifdef TEMP_UART_PARITY_EN
      PARITY,
`endif
      STOP_BIT
   } fsm_t;

   localparam logic [15:0] RELOAD = 16'(CLKS_PER_BIT - 1);

   fsm_t        fsm, fsm_n;
   logic [15:0] cnt, cnt_n;
   logic [2:0]  bit_idx, bit_n;
   logic [3:0]  byte_idx, byte_n;
   logic [7:0]  sh, sh_n;
   logic        done_n;
   logic        snap_en;
   logic [7:0]  chr;

   logic       s_tsgn, s_dsgn;
   logic [3:0] s_th, s_tt, s_to;
   logic [3:0] s_dh, s_dt, s_do;
   logic [1:0] s_st;

`ifdef TEMP_UART_PARITY_EN
   logic par, par_n;
`endif

   function automatic logic [7:0] dig(input logic [3:0] d);
      return (d > 4'd9) ? 8'h3F : {4'h3, d};
   endfunction

   function automatic logic [7:0] sgn(input logic s);
      return s ? 8'h2D : 8'h2B;
   endfunction

   always_comb begin
      chr = 8'h20;
      case (byte_idx)
         4'd0:  chr = 8'h54;
         4'd1:  chr = sgn(s_tsgn);
         4'd2:  chr = dig(s_th);
         4'd3:  chr = dig(s_tt);
         4'd4:  chr = dig(s_to);
         4'd5:  chr = 8'h20;
         4'd6:  chr = 8'h44;
         4'd7:  chr = sgn(s_dsgn);
         4'd8:  chr = dig(s_dh);
         4'd9:  chr = dig(s_dt);
         4'd10: chr = dig(s_do);
         4'd11: chr = 8'h20;
         4'd12: chr = 8'h53;
         4'd13: chr = {6'b001100, s_st};
         4'd14: chr = 8'h0D;
         4'd15: chr = 8'h0A;
         default: chr = 8'h20;
      endcase
   end

   always_comb begin
      fsm_n   = fsm;
      cnt_n   = cnt;
      bit_n   = bit_idx;
      byte_n  = byte_idx;
      sh_n    = sh;
      done_n  = 1'b0;
      snap_en = 1'b0;
`ifdef TEMP_UART_PARITY_EN
      par_n   = par;
`endif
      unique case (fsm)
         IDLE: begin
            if (start) begin
               snap_en = 1'b1;
               fsm_n   = START_BIT;
               cnt_n   = RELOAD;
               byte_n  = 4'd0;
            end
         end
         START_BIT: begin
            if (cnt == 16'd0) begin
               fsm_n = DATA;
               cnt_n = RELOAD;
               bit_n = 3'd0;
               sh_n  = chr;
`ifdef TEMP_UART_PARITY_EN
               par_n = ^chr;
`endif
            end else begin
               cnt_n = cnt - 16'd1;
            end
         end
         DATA: begin
            if (cnt == 16'd0) begin
               cnt_n = RELOAD;
               sh_n  = {1'b0, sh[7:1]};
               if (bit_idx == 3'd7) begin
`ifdef TEMP_UART_PARITY_EN
                  fsm_n = PARITY;
`else
                  fsm_n = STOP_BIT;
`endif
               end else begin
                  bit_n = bit_idx + 3'd1;
               end
            end else begin
               cnt_n = cnt - 16'd1;
            end
         end
`ifdef TEMP_UART_PARITY_EN
         PARITY: begin
            if (cnt == 16'd0) begin
               fsm_n = STOP_BIT;
               cnt_n = RELOAD;
            end else begin
               cnt_n = cnt - 16'd1;
            end
         end
`endif
         STOP_BIT: begin
            if (cnt == 16'd0) begin
               if (byte_idx == 4'd15) begin
                  fsm_n  = IDLE;
                  byte_n = 4'd0;
                  done_n = 1'b1;
               end else begin
                  fsm_n  = START_BIT;
                  byte_n = byte_idx + 4'd1;
                  cnt_n  = RELOAD;
               end
            end else begin
               cnt_n = cnt - 16'd1;
            end
         end
         default: fsm_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm      <= IDLE;
         cnt      <= 16'd0;
         bit_idx  <= 3'd0;
         byte_idx <= 4'd0;
         sh       <= 8'd0;
         done     <= 1'b0;
`ifdef TEMP_UART_PARITY_EN
         par      <= 1'b0;
`endif
      end else begin
         fsm      <= fsm_n;
         cnt      <= cnt_n;
         bit_idx  <= bit_n;
         byte_idx <= byte_n;
         sh       <= sh_n;
         done     <= done_n;
`ifdef TEMP_UART_PARITY_EN
         par      <= par_n;
`endif
      end
   end

   // Snapshot freezes the line content for the whole transmission
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_tsgn <= 1'b0;
         s_th   <= 4'd0;
         s_tt   <= 4'd0;
         s_to   <= 4'd0;
         s_dsgn <= 1'b0;
         s_dh   <= 4'd0;
         s_dt   <= 4'd0;
         s_do   <= 4'd0;
         s_st   <= 2'd0;
      end else if (snap_en) begin
         s_tsgn <= temp_value_sign;
         s_th   <= temp_value_huns;
         s_tt   <= temp_value_tens;
         s_to   <= temp_value_ones;
         s_dsgn <= temp_delta_sign;
         s_dh   <= temp_delta_huns;
         s_dt   <= temp_delta_tens;
         s_do   <= temp_delta_ones;
         s_st   <= state;
      end
   end

   always_comb begin
      tx = 1'b1;
      unique case (1'b1)
         (fsm == START_BIT): tx = 1'b0;
         (fsm == DATA):      tx = sh[0];
`ifdef TEMP_UART_PARITY_EN
         (fsm == PARITY):    tx = par;
`endif
         default:            tx = 1'b1;
      endcase
   end

   assign busy = (fsm != IDLE);

endmodule

// File: tb/tb_temp_uart_tx.sv
// Directed bench for temp_uart_tx with a cycle-stepped UART receiver.
module tb_temp_uart_tx;

   localparam int CPB = 4;
`ifdef TEMP_UART_PARITY_EN
   localparam int BITS = 11;
`else
   localparam int BITS = 10;
`endif
   localparam int LINE = 16 * BITS * CPB;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [3:0] temp_value_ones = 4'd0;
   logic [3:0] temp_value_tens = 4'd0;
   logic [3:0] temp_value_huns = 4'd0;
   logic       temp_value_sign = 1'b0;
   logic [3:0] temp_delta_ones = 4'd0;
   logic [3:0] temp_delta_tens = 4'd0;
   logic [3:0] temp_delta_huns = 4'd0;
   logic       temp_delta_sign = 1'b0;
   logic [1:0] state = 2'd0;
   logic       tx, busy, done;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int busy_cyc = 0;
   int done_cnt = 0;
   int last_done = 0;
   logic [7:0] rx_buf [16];
   int rx_k0 = 0;

   temp_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
      .temp_value_ones(temp_value_ones),
      .temp_value_tens(temp_value_tens),
      .temp_value_huns(temp_value_huns),
      .temp_value_sign(temp_value_sign),
      .temp_delta_ones(temp_delta_ones),
      .temp_delta_tens(temp_delta_tens),
      .temp_delta_huns(temp_delta_huns),
      .temp_delta_sign(temp_delta_sign),
      .state(state),
      .tx(tx),
      .busy(busy),
      .done(done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (busy) busy_cyc <= busy_cyc + 1;
      if (done) begin
         done_cnt  <= done_cnt + 1;
         last_done <= cyc;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic set_in(input logic ts, input logic [3:0] th,
                         input logic [3:0] tt, input logic [3:0] to,
                         input logic ds, input logic [3:0] dh,
                         input logic [3:0] dt, input logic [3:0] dn,
                         input logic [1:0] st);
      temp_value_sign = ts;
      temp_value_huns = th;
      temp_value_tens = tt;
      temp_value_ones = to;
      temp_delta_sign = ds;
      temp_delta_huns = dh;
      temp_delta_tens = dt;
      temp_delta_ones = dn;
      state = st;
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic recv_line(input string tag);
      logic [7:0] d;
      logic ok;
      for (int b = 0; b < 16; b++) rx_buf[b] = 8'h00;
      for (int b = 0; b < 16; b++) begin
         ok = 1'b0;
         for (int n = 0; n < 80; n++) begin
            @(negedge clk);
            if (tx === 1'b0) begin
               ok = 1'b1;
               break;
            end
         end
         chk($sformatf("%s start%0d", tag, b), 32'(ok), 32'd1);
         if (!ok) return;
         if (b == 0) rx_k0 = cyc;
         @(negedge clk);
         d = 8'h00;
         for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            d[i] = tx;
         end
`ifdef TEMP_UART_PARITY_EN
         repeat (CPB) @(negedge clk);
         chk($sformatf("%s par%0d", tag, b), 32'(tx), 32'(^d));
`endif
         repeat (CPB) @(negedge clk);
         chk($sformatf("%s stop%0d", tag, b), 32'(tx), 32'd1);
         rx_buf[b] = d;
      end
   endtask

   task automatic check_line(input string tag, input string exp);
      for (int i = 0; i < 16; i++)
         chk($sformatf("%s b%0d", tag, i), 32'(rx_buf[i]), 32'(exp[i]));
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int b0, d0, bad;

      // 1: reset and idle
      repeat (3) @(negedge clk);
      chk("rst tx", 32'(tx), 32'd1);
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst done", 32'(done), 32'd0);
      rst_n = 1'b1;
      bad = 0;
      repeat (100) begin
         @(negedge clk);
         if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
      end
      chk("idle", 32'(bad), 32'd0);

      // 2: basic line, latency, busy length, done count
      set_in(1'b1, 4'd1, 4'd2, 4'd3, 1'b0, 4'd0, 4'd0, 4'd5, 2'd2);
      b0 = busy_cyc;
      d0 = done_cnt;
      pulse_start();
      chk("lat tx", 32'(tx), 32'd0);
      chk("lat busy", 32'(busy), 32'd1);
      recv_line("l2");
      check_line("l2", "T-123 D+005 S2\r\n");
      repeat (20) @(negedge clk);
      chk("l2 busy", 32'(busy_cyc - b0), 32'(LINE));
      chk("l2 done", 32'(done_cnt - d0), 32'd1);

      // 3: inputs change mid-line are ignored
      pulse_start();
      fork
         recv_line("l3");
         begin
            repeat (3 * BITS * CPB + 5) @(negedge clk);
            set_in(1'b0, 4'd9, 4'd9, 4'd9, 1'b0, 4'd0, 4'd0, 4'd5, 2'd0);
         end
      join
      check_line("l3", "T-123 D+005 S2\r\n");
      repeat (20) @(negedge clk);
      pulse_start();
      recv_line("l3b");
      check_line("l3b", "T+999 D+005 S0\r\n");
      repeat (20) @(negedge clk);

      // 4: non-BCD nibble
      set_in(1'b0, 4'd1, 4'hC, 4'd3, 1'b0, 4'd0, 4'd0, 4'd5, 2'd0);
      pulse_start();
      recv_line("l4");
      check_line("l4", "T+1?3 D+005 S0\r\n");
      repeat (20) @(negedge clk);

      // 5: start while busy is dropped; held start gives back-to-back
      set_in(1'b0, 4'd9, 4'd9, 4'd9, 1'b0, 4'd0, 4'd0, 4'd5, 2'd0);
      b0 = busy_cyc;
      d0 = done_cnt;
      pulse_start();
      fork
         recv_line("l5");
         begin
            repeat (5 * BITS * CPB + 6) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
         end
      join
      check_line("l5", "T+999 D+005 S0\r\n");
      repeat (60) @(negedge clk);
      chk("l5 busy", 32'(busy_cyc - b0), 32'(LINE));
      chk("l5 done", 32'(done_cnt - d0), 32'd1);

      @(negedge clk);
      start = 1'b1;
      recv_line("h1");
      check_line("h1", "T+999 D+005 S0\r\n");
      fork
         recv_line("h2");
         begin
            repeat (50) @(negedge clk);
            start = 1'b0;
         end
      join
      check_line("h2", "T+999 D+005 S0\r\n");
      chk("gap", 32'(rx_k0 - last_done), 32'd1);
      repeat (20) @(negedge clk);

      // 6: reset mid-line aborts, then a clean line
      pulse_start();
      repeat (7 * BITS * CPB + 10) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("ab tx", 32'(tx), 32'd1);
      chk("ab busy", 32'(busy), 32'd0);
      chk("ab done", 32'(done), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      b0 = busy_cyc;
      repeat (30) @(negedge clk);
      chk("ab idle", 32'(busy_cyc - b0), 32'd0);
      set_in(1'b1, 4'd0, 4'd4, 4'd5, 1'b1, 4'd1, 4'd0, 4'd0, 2'd3);
      b0 = busy_cyc;
      pulse_start();
      recv_line("l6");
      check_line("l6", "T-045 D-100 S3\r\n");
      repeat (20) @(negedge clk);
      chk("l6 busy", 32'(busy_cyc - b0), 32'(LINE));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
